ling_mod_adder_arbiter: RTL and testbench



---
 rtl/ling_mod_adder_arbiter.sv | 119 +++++++++++
 tb/tb_ling_mod_adder_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ling_mod_adder_arbiter.sv
// Round-robin arbiter sharing one modulo-255 end-around-carry adder among N_REQ requesters,
// behind a two-stage pipeline (operand register, result register) with valid/ready on both sides.
`timescale 1ns/1ps

module ling_mod_adder_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   output logic [WIDTH-1:0]       rsp_sum,
   output logic [ID_W-1:0]        rsp_id,
   input  logic                   rsp_ready,
   output logic                   busy
);

   if (WIDTH != 8) begin : g_width_check
      $error("ling_mod_adder_arbiter: WIDTH must be 8");
   end
   if (N_REQ < 2 || N_REQ > 8) begin : g_nreq_check
      $error("ling_mod_adder_arbiter: N_REQ must be in 2..8");
   end

   // End-around carry: a set carry-out is worth 256 = 255 + 1, so it folds back in as +1.
   // The carry case leaves at most 0xFE in the low bits, so the fold never overflows.
   function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, s[WIDTH]};
   endfunction

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [ID_W-1:0]  s1_id;
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  ptr_next;
   logic [ID_W-1:0]  grant;
   logic [ID_W:0]    cand;
   logic             grant_valid;
   logic             adv_out;
   logic             accept;
   logic             take;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   assign adv_out = !rsp_valid || rsp_ready;
   assign accept  = !s1_valid || adv_out;
   assign take    = accept && grant_valid;
   assign busy    = s1_valid || rsp_valid;
   assign sel_a   = req_a[grant*WIDTH +: WIDTH];
   assign sel_b   = req_b[grant*WIDTH +: WIDTH];

   // Scan from ptr upward with wrap; cand carries one extra bit so the wrap is a single subtract.
   always_comb begin
      grant_valid = 1'b0;
      grant       = '0;
      cand        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, ptr} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(N_REQ)) begin
            cand = cand - (ID_W+1)'(N_REQ);
         end
         if (!grant_valid && req_valid[cand[ID_W-1:0]]) begin
            grant_valid = 1'b1;
            grant       = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      ptr_next = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
   end

   // Grant is withheld during reset so no requester sees a handshake that the flops will drop.
   always_comb begin
      req_ready = '0;
      if (accept && grant_valid && !rst) begin
         req_ready[grant] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_id     <= '0;
         ptr       <= '0;
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_id    <= '0;
      end else begin
         if (adv_out) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
               rsp_sum <= mod_add(s1_a, s1_b);
               rsp_id  <= s1_id;
            end
         end
         if (accept) begin
            s1_valid <= grant_valid;
            if (take) begin
               s1_a  <= sel_a;
               s1_b  <= sel_b;
               s1_id <= grant;
               ptr   <= ptr_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_ling_mod_adder_arbiter.sv
// Directed bench for ling_mod_adder_arbiter: arithmetic corners, random sums, round-robin order,
// backpressure, simultaneous retire/accept and asynchronous reset in flight.
`timescale 1ns/1ps

module tb_ling_mod_adder_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [7:0]  rsp_sum;
   logic [1:0]  rsp_id;
   logic        rsp_ready = 1'b1;
   logic        busy;

   int total = 0;
   int bad = 0;

   ling_mod_adder_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 9'd256) s = s - 9'd255;
      return s[7:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
      req_valid[i]     = 1'b1;
      req_a[i*8 +: 8]  = a;
      req_b[i*8 +: 8]  = b;
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic do_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
      logic [3:0] oh;
      oh = 4'b0001 << i;
      set_req(i, a, b);
      #1;
      check_output("op_grant", {28'd0, req_ready}, {28'd0, oh});
      tick();
      req_valid = '0;
      check_output("op_inflight", {30'd0, busy, rsp_valid}, 32'b10);
      tick();
      check_output("op_result", {21'd0, rsp_valid, rsp_id, rsp_sum}, {21'd0, 1'b1, 2'(i), exp});
      tick();
      check_output("op_drained", {30'd0, busy, rsp_valid}, 32'd0);
   endtask

   initial begin
      logic [7:0] ra, rb, e;
      logic [7:0] exp_q[$];
      logic [3:0] got;
      int acc;

      // Reset state, including req_ready held low while requests are present.
      req_valid = 4'b1111;
      #3;
      check_output("rst_ready", {28'd0, req_ready}, 32'd0);
      check_output("rst_outputs", {20'd0, rsp_valid, busy, rsp_id, rsp_sum}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      #1;
      check_output("post_rst", {30'd0, busy, rsp_valid}, 32'd0);

      // Single op and arithmetic corners.
      do_op(2, 8'h80, 8'h80, 8'h01);
      do_op(0, 8'hFF, 8'h01, 8'h01);
      do_op(1, 8'h01, 8'hFE, 8'hFF);
      do_op(3, 8'hFF, 8'hFF, 8'hFF);
      do_op(0, 8'h00, 8'h00, 8'h00);
      do_op(2, 8'h7F, 8'h80, 8'hFF);
      do_op(1, 8'hFF, 8'h00, 8'hFF);

      // Random pairs at full throughput from requester 1.
      for (int j = 0; j < 10000; j++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         set_req(1, ra, rb);
         exp_q.push_back(model(ra, rb));
         tick();
         if (j >= 1) begin
            e = exp_q.pop_front();
            check_output("rand", {21'd0, rsp_valid, rsp_id, rsp_sum}, {21'd0, 1'b1, 2'd1, e});
         end
      end
      req_valid = '0;
      tick();
      e = exp_q.pop_front();
      check_output("rand_last", {21'd0, rsp_valid, rsp_id, rsp_sum}, {21'd0, 1'b1, 2'd1, e});
      tick();

      // Round-robin with all four requesters continuously valid.
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'h10);
      #1;
      for (int c = 0; c < 8; c++) begin
         check_output("rr_grant", {28'd0, req_ready}, {28'd0, 4'b0001 << (c % 4)});
         tick();
         if (c >= 1) check_output("rr_id", {29'd0, rsp_valid, rsp_id}, {29'd0, 1'b1, 2'((c - 1) % 4)});
      end
      req_valid = '0;
      tick();
      check_output("rr_id_last", {29'd0, rsp_valid, rsp_id}, {29'd0, 1'b1, 2'd3});
      tick();
      check_output("rr_drained", {31'd0, busy}, 32'd0);

      // Backpressure: three pending, only two fit.
      do_reset();
      rsp_ready = 1'b0;
      set_req(0, 8'h10, 8'h20);
      set_req(1, 8'hF0, 8'h20);
      set_req(2, 8'h33, 8'h44);
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (c >= 2) check_output("bp_ready_low", {28'd0, req_ready}, 32'd0);
         got = req_ready & req_valid;
         acc += $countones(got);
         tick();
         req_valid = req_valid & ~got;
         if (c >= 1) check_output("bp_hold", {21'd0, rsp_valid, rsp_id, rsp_sum}, {21'd0, 1'b1, 2'd0, 8'h30});
      end
      check_output("bp_accepts", acc, 32'd2);
      rsp_ready = 1'b1;
      #1;
      check_output("bp_reassert", {28'd0, req_ready}, {28'd0, 4'b0100});
      tick();
      req_valid = '0;
      check_output("bp_ret1", {21'd0, rsp_valid, rsp_id, rsp_sum}, {21'd0, 1'b1, 2'd1, 8'h11});
      tick();
      check_output("bp_ret2", {21'd0, rsp_valid, rsp_id, rsp_sum}, {21'd0, 1'b1, 2'd2, 8'h77});
      tick();
      check_output("bp_drained", {30'd0, busy, rsp_valid}, 32'd0);

      // Simultaneous retire, advance and accept on one edge.
      do_reset();
      rsp_ready = 1'b0;
      set_req(1, 8'h01, 8'h02);
      set_req(2, 8'h05, 8'h06);
      #1;
      check_output("sim_g1", {28'd0, req_ready}, {28'd0, 4'b0010});
      tick();
      req_valid[1] = 1'b0;
      #1;
      check_output("sim_g2", {28'd0, req_ready}, {28'd0, 4'b0100});
      tick();
      req_valid[2] = 1'b0;
      check_output("sim_out1", {21'd0, rsp_valid, rsp_id, rsp_sum}, {21'd0, 1'b1, 2'd1, 8'h03});
      set_req(3, 8'hFE, 8'h03);
      #1;
      check_output("sim_full", {28'd0, req_ready}, 32'd0);
      rsp_ready = 1'b1;
      #1;
      check_output("sim_g3", {28'd0, req_ready}, {28'd0, 4'b1000});
      tick();
      req_valid[3] = 1'b0;
      check_output("sim_out2", {21'd0, rsp_valid, rsp_id, rsp_sum}, {21'd0, 1'b1, 2'd2, 8'h0B});
      req_valid = 4'b1111;
      #1;
      check_output("sim_ptr0", {28'd0, req_ready}, {28'd0, 4'b0001});
      req_valid = '0;
      tick();
      check_output("sim_out3", {21'd0, rsp_valid, rsp_id, rsp_sum}, {21'd0, 1'b1, 2'd3, 8'h02});
      tick();
      check_output("sim_drained", {31'd0, busy}, 32'd0);

      // Asynchronous reset with both stages full.
      rsp_ready = 1'b0;
      set_req(0, 8'h11, 8'h22);
      set_req(1, 8'h33, 8'h44);
      #1;
      tick();
      req_valid[0] = 1'b0;
      #1;
      tick();
      req_valid[1] = 1'b0;
      check_output("mr_full", {30'd0, busy, rsp_valid}, 32'b11);
      set_req(0, 8'h7F, 8'h80);
      req_valid = 4'b1111;
      #1;
      check_output("mr_ready_low", {28'd0, req_ready}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check_output("mr_drop", {26'd0, rsp_valid, busy, req_ready}, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check_output("mr_first_grant", {28'd0, req_ready}, {28'd0, 4'b0001});
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      check_output("mr_no_stale", {31'd0, rsp_valid}, 32'd0);
      tick();
      check_output("mr_result", {21'd0, rsp_valid, rsp_id, rsp_sum}, {21'd0, 1'b1, 2'd0, 8'hFF});
      tick();
      check_output("mr_drained", {31'd0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
